// File: rtl/risc16_control_fsm.sv
// Multicycle control unit for the RISC-16 core.
// Sequences fetch/decode/execute/memory/writeback, stalls on memory,
// traps to a fault state on a memory timeout and counts retired instructions.
module risc16_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             PC_enable,
    output logic             pc_increment,
    output logic             IR_enable,
    output logic             mem_enable,
    output logic             mem_write,
    output logic             reg_enable,
    output logic [2:0]       alu_op,
    output logic [2:0]       state_dbg,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    // The counter only has to hold 0 .. WAIT_LIMIT-1; the limit is hit on the last value.
    localparam int unsigned WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q;
    logic [CNT_W-1:0] retired_q;

    logic pc_en, pc_inc, ir_en, mem_en, mem_wr, reg_en, retire, wait_hit;

    // Next-state and strobe decode from the current state and live inputs.
    always_comb begin
        pc_en    = 1'b0;
        pc_inc   = 1'b1;
        ir_en    = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        reg_en   = 1'b0;
        retire   = 1'b0;
        state_d  = state_q;
        wait_hit = (wait_q == WCW'(WAIT_LIMIT - 1));
        case (state_q)
            StFetch: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end else if (wait_hit) begin
                    state_d = StFault;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                case (opcode)
                    4'h8, 4'h9: state_d = StMem;
                    4'hA, 4'hB: begin
                        // Taken branch selects the target: BEQ on zero, BNE on non-zero.
                        pc_en   = 1'b1;
                        pc_inc  = (opcode == 4'hA) ? ~zero_flag : zero_flag;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    4'hC: begin
                        pc_en   = 1'b1;
                        pc_inc  = 1'b0;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    4'hD, 4'hE: begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    4'hF: begin
                        retire  = 1'b1;
                        state_d = StHalt;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                mem_en = 1'b1;
                mem_wr = (opcode == 4'h9);
                if (mem_ready) begin
                    if (opcode == 4'h9) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_hit) begin
                    state_d = StFault;
                end
            end
            StWb: begin
                reg_en  = 1'b1;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt, StFault: state_d = state_q;
            default: state_d = StFault;
        endcase
    end

    // ALU function select depends only on the instruction class.
    always_comb begin
        if (!opcode[3]) begin
            alu_op = opcode[2:0];
        end else if (opcode == 4'hA || opcode == 4'hB) begin
            alu_op = 3'b001;
        end else begin
            alu_op = 3'b000;
        end
    end

    // State, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            // Restart the count on any state change (covers entry to fetch/mem) or on completion.
            if (mem_ready || (state_d != state_q) ||
                !((state_q == StFetch) || (state_q == StMem))) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_q + WCW'(1);
            end
        end
    end

    // Strobes are forced low while reset is held so they drop without waiting for a clock.
    always_comb begin
        PC_enable    = rst & pc_en;
        pc_increment = ~(rst & pc_en) | pc_inc;
        IR_enable    = rst & ir_en;
        mem_enable   = rst & mem_en;
        mem_write    = rst & mem_en & mem_wr;
        reg_enable   = rst & reg_en;
        state_dbg    = state_q;
        halted       = (state_q == StHalt);
        fault        = (state_q == StFault);
        retired      = retired_q;
    end

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Scoreboard bench for risc16_control_fsm: a default instance and a 4-bit counter instance
// share stimulus; per-cycle expectations are queued and compared at the falling edge.
module tb_risc16_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;

    logic        PC_enable, pc_increment, IR_enable, mem_enable, mem_write, reg_enable;
    logic [2:0]  alu_op, state_dbg;
    logic        halted, fault;
    logic [15:0] retired;

    logic        pce4, pci4, ire4, me4, mw4, re4, h4, f4;
    logic [2:0]  alu4, st4;
    logic [3:0]  ret4;

    int total = 0;
    int bad   = 0;
    int ret   = 0;

    logic [5:0]  stim_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] obs;

    always #5 clk = ~clk;

    risc16_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .PC_enable(PC_enable), .pc_increment(pc_increment), .IR_enable(IR_enable),
        .mem_enable(mem_enable), .mem_write(mem_write), .reg_enable(reg_enable),
        .alu_op(alu_op), .state_dbg(state_dbg), .halted(halted), .fault(fault),
        .retired(retired)
    );

    risc16_control_fsm #(.WAIT_LIMIT(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .PC_enable(pce4), .pc_increment(pci4), .IR_enable(ire4),
        .mem_enable(me4), .mem_write(mw4), .reg_enable(re4),
        .alu_op(alu4), .state_dbg(st4), .halted(h4), .fault(f4),
        .retired(ret4)
    );

    assign obs = {state_dbg, PC_enable, pc_increment, IR_enable, mem_enable, mem_write,
                  reg_enable, alu_op, halted, fault, retired,
                  st4, pce4, pci4, ire4, me4, mw4, re4, alu4, h4, f4, ret4};

    function automatic logic [47:0] mk(input int st, input bit pce, input bit pci,
                                       input bit ire, input bit me, input bit mw,
                                       input bit re, input int alu, input int r);
        logic [13:0] f;
        logic [15:0] rv;
        rv = r[15:0];
        f  = {st[2:0], pce, pci, ire, me, mw, re, alu[2:0], st == 5, st == 6};
        return {f, rv, f, rv[3:0]};
    endfunction

    function automatic int alu_of(input logic [3:0] op);
        if (op < 4'h8) return int'(op[2:0]);
        if (op == 4'hA || op == 4'hB) return 1;
        return 0;
    endfunction

    task automatic push(input logic [3:0] op, input bit zf, input bit rdy, input logic [47:0] e);
        stim_q.push_back({op, zf, rdy});
        exp_q.push_back(e);
    endtask

    // Queue one whole instruction: fw/mw are zero-ready cycles in fetch/mem before completion.
    task automatic push_instr(input logic [3:0] op, input bit zf, input int fw, input int mw);
        int a;
        bit taken;
        a = alu_of(op);
        for (int i = 0; i < fw; i++) push(op, zf, 1'b0, mk(0, 0, 1, 0, 1, 0, 0, a, ret));
        push(op, zf, 1'b1, mk(0, 0, 1, 1, 1, 0, 0, a, ret));
        push(op, zf, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, a, ret));
        case (op)
            4'h8, 4'h9: begin
                push(op, zf, 1'b1, mk(2, 0, 1, 0, 0, 0, 0, a, ret));
                for (int i = 0; i < mw; i++)
                    push(op, zf, 1'b0, mk(3, 0, 1, 0, 1, op == 4'h9, 0, a, ret));
                if (op == 4'h8) begin
                    push(op, zf, 1'b1, mk(3, 0, 1, 0, 1, 0, 0, a, ret));
                    push(op, zf, 1'b1, mk(4, 1, 1, 0, 0, 0, 1, a, ret));
                end else begin
                    push(op, zf, 1'b1, mk(3, 1, 1, 0, 1, 1, 0, a, ret));
                end
            end
            4'hA, 4'hB: begin
                taken = (op == 4'hA) ? zf : !zf;
                push(op, zf, 1'b1, mk(2, 1, !taken, 0, 0, 0, 0, a, ret));
            end
            4'hC:       push(op, zf, 1'b1, mk(2, 1, 0, 0, 0, 0, 0, a, ret));
            4'hD, 4'hE: push(op, zf, 1'b1, mk(2, 1, 1, 0, 0, 0, 0, a, ret));
            4'hF:       push(op, zf, 1'b1, mk(2, 0, 1, 0, 0, 0, 0, a, ret));
            default: begin
                push(op, zf, 1'b1, mk(2, 0, 1, 0, 0, 0, 0, a, ret));
                push(op, zf, 1'b1, mk(4, 1, 1, 0, 0, 0, 1, a, ret));
            end
        endcase
        ret++;
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        ret = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = 4'h0;
        #1 rst = 1'b0;
        #1;
        total++;
        if (obs !== mk(0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_alu();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        do_reset();
        push_instr(4'h0, 1'b0, 0, 0);
        push_instr(4'h4, 1'b0, 0, 0);
        push_instr(4'h7, 1'b1, 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            total++; n++;
            if (obs !== e) begin
                bad++;
                $display("FAIL alu cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        do_reset();
        push_instr(4'h8, 1'b0, 0, 3);
        push_instr(4'h9, 1'b0, 0, 0);
        push_instr(4'h8, 1'b0, 7, 7);
        push_instr(4'h9, 1'b1, 2, 7);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            total++; n++;
            if (obs !== e) begin
                bad++;
                $display("FAIL mem cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        do_reset();
        push_instr(4'hA, 1'b1, 0, 0);
        push_instr(4'hA, 1'b0, 0, 0);
        push_instr(4'hB, 1'b1, 0, 0);
        push_instr(4'hB, 1'b0, 0, 0);
        push_instr(4'hC, 1'b1, 0, 0);
        push_instr(4'hD, 1'b0, 0, 0);
        push_instr(4'hE, 1'b1, 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            total++; n++;
            if (obs !== e) begin
                bad++;
                $display("FAIL branch cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fault();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        // Fetch timeout, then a store timing out in the memory state.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            if (pass == 0) begin
                for (int i = 0; i < 8; i++) push(4'h0, 1'b0, 1'b0, mk(0, 0, 1, 0, 1, 0, 0, 0, ret));
            end else begin
                push(4'h9, 1'b0, 1'b1, mk(0, 0, 1, 1, 1, 0, 0, 0, ret));
                push(4'h9, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, ret));
                push(4'h9, 1'b0, 1'b1, mk(2, 0, 1, 0, 0, 0, 0, 0, ret));
                for (int i = 0; i < 8; i++) push(4'h9, 1'b0, 1'b0, mk(3, 0, 1, 0, 1, 1, 0, 0, ret));
            end
            for (int i = 0; i < 3; i++) push(4'h0, 1'b0, 1'b1, mk(6, 0, 1, 0, 0, 0, 0, 0, ret));
            while (exp_q.size() != 0) begin
                s = stim_q.pop_front();
                opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
                @(negedge clk);
                e = exp_q.pop_front();
                total++; n++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL fault cycle %0d: got %h want %h", n, obs, e);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_halt_reset();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        for (int pass = 0; pass < 3; pass++) begin
            if (pass != 2) do_reset();
            if (pass == 0) begin
                push_instr(4'hF, 1'b0, 0, 0);
                for (int i = 0; i < 3; i++) push(4'hF, 1'b0, 1'b1, mk(5, 0, 1, 0, 0, 0, 0, 0, ret));
            end else if (pass == 1) begin
                push_instr(4'h0, 1'b0, 0, 0);
                push(4'h8, 1'b0, 1'b1, mk(0, 0, 1, 1, 1, 0, 0, 0, ret));
                push(4'h8, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, ret));
                push(4'h8, 1'b0, 1'b1, mk(2, 0, 1, 0, 0, 0, 0, 0, ret));
                push(4'h8, 1'b0, 1'b0, mk(3, 0, 1, 0, 1, 0, 0, 0, ret));
            end else begin
                push_instr(4'h1, 1'b0, 0, 0);
            end
            while (exp_q.size() != 0) begin
                s = stim_q.pop_front();
                opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
                @(negedge clk);
                e = exp_q.pop_front();
                total++; n++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL halt cycle %0d: got %h want %h", n, obs, e);
                end
                @(posedge clk);
                #1;
            end
            if (pass == 1) begin
                // Drop reset between clock edges while a load waits in the memory state.
                mem_ready = 1'b0;
                #2 rst = 1'b0;
                #1;
                total++;
                if (obs !== mk(0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
                    bad++;
                    $display("FAIL async_reset: got %h want %h", obs, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
                end
                @(posedge clk);
                #1 rst = 1'b1;
                ret = 0;
            end
        end
    endtask

    task automatic test_wrap();
        logic [5:0] s;
        logic [47:0] e;
        int n = 0;
        do_reset();
        for (int i = 0; i < 16; i++) push_instr(4'hD, 1'b0, 0, 0);
        push_instr(4'hE, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            opcode = s[5:2]; zero_flag = s[1]; mem_ready = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            total++; n++;
            if (obs !== e) begin
                bad++;
                $display("FAIL wrap cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_fault();
        test_halt_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
